// File: rtl/range_session_arbiter.sv
// range_session_arbiter
//   Shares one range-finder datapath among NUM_REQ sample-stream clients.
//   Round-robin grant, one session at a time. Sequences rf_go/rf_finish for
//   the granted client, repeats the held sample across stream stalls, aborts
//   a session after TIMEOUT idle stream cycles, and returns the captured
//   range on a valid/ack result port.
// Ports
//   clock, reset          clock (posedge), asynchronous active-high reset
//   req                   per-client session request (level)
//   sample_valid/last     per-client sample handshake, last = final sample
//   sample_data           client i sample at [i*WIDTH +: WIDTH]
//   grant                 one-hot datapath owner, 0 when idle
//   sample_ready          accept strobe toward the granted client
//   rf_data_in/go/finish  range finder drive
//   rf_range, rf_error    range finder result and error flag
//   result/_id/_err       captured range, owning client, error flag
//   result_valid/ack      result held until acknowledged
//   busy                  session in progress
module range_session_arbiter #(
   parameter int  WIDTH   = 16,
   parameter int  NUM_REQ = 4,
   parameter int  TIMEOUT = 64,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       sample_valid,
   input  logic [NUM_REQ-1:0]       sample_last,
   input  logic [NUM_REQ*WIDTH-1:0] sample_data,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       sample_ready,
   output logic [WIDTH-1:0]         rf_data_in,
   output logic                     rf_go,
   output logic                     rf_finish,
   input  logic [WIDTH-1:0]         rf_range,
   input  logic                     rf_error,
   output logic [WIDTH-1:0]         result,
   output logic [IDW-1:0]           result_id,
   output logic                     result_err,
   output logic                     result_valid,
   input  logic                     result_ack,
   output logic                     busy
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_FIRST, S_ONE, S_STREAM, S_CAPTURE, S_RESULT
   } state_t;

   state_t             state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     gidx_q;
   logic [WIDTH-1:0]   hold_q;
   logic [TW-1:0]      timer_q;
   logic               err_q;
   logic [WIDTH-1:0]   result_q;
   logic [IDW-1:0]     result_id_q;
   logic               result_err_q;

   logic               pick_found;
   logic [IDW-1:0]     pick_idx;
   logic [IDW-1:0]     cand;
   logic               valid_g;
   logic               last_g;
   logic [WIDTH-1:0]   data_g;
   logic               tmo;

   // Granted client's lane; other clients' inputs never reach the datapath.
   assign valid_g = sample_valid[gidx_q];
   assign last_g  = sample_last[gidx_q];
   assign data_g  = sample_data[32'(gidx_q)*WIDTH +: WIDTH];
   assign tmo     = (timer_q == TW'(TIMEOUT - 1));

   // First requester at or after the pointer, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDW'((32'(ptr_q) + k) % 32'(NUM_REQ));
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      sample_ready = '0;
      rf_go        = 1'b0;
      rf_finish    = 1'b0;
      rf_data_in   = '0;
      case (state_q)
         S_FIRST: begin
            sample_ready = grant_q;
            if (valid_g) begin
               rf_go      = 1'b1;
               rf_data_in = data_g;
            end
         end
         // go and finish cannot coincide, so a 1-sample session finishes
         // one cycle later on the held sample.
         S_ONE: begin
            rf_finish  = 1'b1;
            rf_data_in = hold_q;
         end
         // A stall repeats the held sample, which leaves min/max unchanged.
         S_STREAM: begin
            sample_ready = grant_q;
            rf_data_in   = valid_g ? data_g : hold_q;
            rf_finish    = valid_g ? last_g : tmo;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         ptr_q        <= '0;
         gidx_q       <= '0;
         hold_q       <= '0;
         timer_q      <= '0;
         err_q        <= 1'b0;
         result_q     <= '0;
         result_id_q  <= '0;
         result_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_found) begin
                  grant_q <= NUM_REQ'(1) << pick_idx;
                  gidx_q  <= pick_idx;
                  state_q <= S_FIRST;
               end
            end
            S_FIRST: begin
               if (valid_g) begin
                  hold_q  <= data_g;
                  timer_q <= '0;
                  state_q <= last_g ? S_ONE : S_STREAM;
               end
            end
            S_ONE: state_q <= S_CAPTURE;
            S_STREAM: begin
               if (valid_g) begin
                  hold_q  <= data_g;
                  timer_q <= '0;
                  if (last_g) state_q <= S_CAPTURE;
               end else if (tmo) begin
                  err_q   <= 1'b1;
                  timer_q <= '0;
                  state_q <= S_CAPTURE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            S_CAPTURE: begin
               result_q     <= rf_range;
               result_id_q  <= gidx_q;
               result_err_q <= err_q | rf_error;
               state_q      <= S_RESULT;
            end
            S_RESULT: begin
               if (result_ack) begin
                  grant_q <= '0;
                  ptr_q   <= (gidx_q == IDW'(NUM_REQ - 1)) ? '0 : gidx_q + IDW'(1);
                  err_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant        = grant_q;
   assign result       = result_q;
   assign result_id    = result_id_q;
   assign result_err   = result_err_q;
   assign result_valid = (state_q == S_RESULT);
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_range_session_arbiter.sv
module tb_range_session_arbiter;
   localparam int W = 16;
   localparam int N = 4;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   sample_valid;
   logic [N-1:0]   sample_last;
   logic [N*W-1:0] sample_data;
   logic [N-1:0]   grant;
   logic [N-1:0]   sample_ready;
   logic [W-1:0]   rf_data_in;
   logic           rf_go;
   logic           rf_finish;
   logic [W-1:0]   rf_range;
   logic           rf_error;
   logic [W-1:0]   result;
   logic [1:0]     result_id;
   logic           result_err;
   logic           result_valid;
   logic           result_ack;
   logic           busy;

   int passes = 0;
   int fails  = 0;

   always #5 clock = ~clock;

   range_session_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(8)) dut (
      .clock(clock), .reset(reset), .req(req),
      .sample_valid(sample_valid), .sample_last(sample_last), .sample_data(sample_data),
      .grant(grant), .sample_ready(sample_ready),
      .rf_data_in(rf_data_in), .rf_go(rf_go), .rf_finish(rf_finish),
      .rf_range(rf_range), .rf_error(rf_error),
      .result(result), .result_id(result_id), .result_err(result_err),
      .result_valid(result_valid), .result_ack(result_ack), .busy(busy)
   );

   // Range finder model: range = max - min of all samples from go to finish.
   logic [W-1:0] mn, mx;
   logic         act;

   function automatic logic [W-1:0] fmin(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a < b) ? a : b;
   endfunction
   function automatic logic [W-1:0] fmax(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mn <= '0; mx <= '0; act <= 1'b0; rf_range <= '0;
      end else if (rf_go) begin
         mn <= rf_data_in; mx <= rf_data_in; act <= 1'b1;
      end else if (act) begin
         mn <= fmin(mn, rf_data_in);
         mx <= fmax(mx, rf_data_in);
         if (rf_finish) begin
            rf_range <= fmax(mx, rf_data_in) - fmin(mn, rf_data_in);
            act      <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int c, input logic v, input logic l, input logic [W-1:0] d);
      sample_valid = '0;
      sample_last  = '0;
      sample_data  = '0;
      if (v) begin
         sample_valid[c]        = 1'b1;
         sample_last[c]         = l;
         sample_data[c*W +: W]  = d;
      end
   endtask

   // Single-sample session for an already granted client c.
   task automatic one_sample(input int c, input logic [W-1:0] d, input logic exp_err,
                             input logic [N-1:0] next_req);
      logic [N-1:0] oh;
      oh = 4'b0001 << c;
      @(negedge clock); drive(c, 1'b1, 1'b1, d); #1;
      chk("one_grant", 32'(grant), 32'(oh));
      chk("one_ready", 32'(sample_ready), 32'(oh));
      chk("one_go", 32'(rf_go), 1);
      chk("one_go_fin", 32'(rf_finish), 0);
      chk("one_go_data", 32'(rf_data_in), 32'(d));
      @(negedge clock); drive(0, 1'b0, 1'b0, '0); #1;
      chk("one_fin", 32'(rf_finish), 1);
      chk("one_fin_go", 32'(rf_go), 0);
      chk("one_fin_data", 32'(rf_data_in), 32'(d));
      chk("one_fin_ready", 32'(sample_ready), 0);
      @(negedge clock); #1;
      chk("one_cap_busy", 32'(busy), 1);
      chk("one_cap_rv", 32'(result_valid), 0);
      @(negedge clock); #1;
      chk("one_rv", 32'(result_valid), 1);
      chk("one_result", 32'(result), 0);
      chk("one_id", 32'(result_id), 32'(c));
      chk("one_err", 32'(result_err), 32'(exp_err));
      result_ack = 1'b1;
      @(negedge clock); result_ack = 1'b0; req = next_req; #1;
      chk("one_idle_rv", 32'(result_valid), 0);
      chk("one_idle_grant", 32'(grant), 0);
      chk("one_idle_busy", 32'(busy), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req = '0; result_ack = 1'b0; rf_error = 1'b0;
      drive(0, 1'b0, 1'b0, '0);
      repeat (2) @(negedge clock);
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rv", 32'(result_valid), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_ready", 32'(sample_ready), 0);

      // 1: client 0 streams 5,9,2,7 back-to-back -> range 7
      @(negedge clock); reset = 1'b0; req = 4'b0001; #1;
      chk("t1_pre_grant", 32'(grant), 0);
      @(negedge clock); drive(0, 1'b1, 1'b0, 16'd5); #1;
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_go", 32'(rf_go), 1);
      chk("t1_go_data", 32'(rf_data_in), 5);
      @(negedge clock); drive(0, 1'b1, 1'b0, 16'd9); #1;
      chk("t1_s9_go", 32'(rf_go), 0);
      chk("t1_s9_data", 32'(rf_data_in), 9);
      @(negedge clock); drive(0, 1'b1, 1'b0, 16'd2); #1;
      chk("t1_s2_fin", 32'(rf_finish), 0);
      @(negedge clock); drive(0, 1'b1, 1'b1, 16'd7); #1;
      chk("t1_fin", 32'(rf_finish), 1);
      chk("t1_fin_data", 32'(rf_data_in), 7);
      @(negedge clock); drive(0, 1'b0, 1'b0, '0); req = '0; #1;
      chk("t1_cap_rv", 32'(result_valid), 0);
      chk("t1_cap_fin", 32'(rf_finish), 0);
      @(negedge clock); #1;
      chk("t1_rv", 32'(result_valid), 1);
      chk("t1_result", 32'(result), 7);
      chk("t1_id", 32'(result_id), 0);
      chk("t1_err", 32'(result_err), 0);
      result_ack = 1'b1;
      @(negedge clock); result_ack = 1'b0; #1;
      chk("t1_idle_busy", 32'(busy), 0);

      // 2: after reset req=0101 -> 0, 2, then wrap back to 0
      @(negedge clock); reset = 1'b1; #1;
      @(negedge clock); reset = 1'b0; req = 4'b0101; #1;
      one_sample(0, 16'd11, 1'b0, 4'b0101);
      one_sample(2, 16'd22, 1'b0, 4'b0101);
      one_sample(0, 16'd33, 1'b0, 4'b0010);

      // 3: client 1: 10, three stalls, 4(last) -> range 6; ack withheld 5 cycles
      @(negedge clock); drive(1, 1'b1, 1'b0, 16'd10); #1;
      chk("t3_grant", 32'(grant), 32'h2);
      chk("t3_go", 32'(rf_go), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         sample_valid = 4'b1000; sample_last = 4'b1000;
         sample_data = '0; sample_data[3*W +: W] = 16'd999;
         #1;
         chk("t3_gap_data", 32'(rf_data_in), 10);
         chk("t3_gap_fin", 32'(rf_finish), 0);
         chk("t3_gap_ready", 32'(sample_ready), 32'h2);
      end
      @(negedge clock); drive(1, 1'b1, 1'b1, 16'd4); #1;
      chk("t3_fin", 32'(rf_finish), 1);
      chk("t3_fin_data", 32'(rf_data_in), 4);
      @(negedge clock); drive(0, 1'b0, 1'b0, '0); req = 4'b1111; #1;
      chk("t3_cap_rv", 32'(result_valid), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock); #1;
         chk("t3_hold_rv", 32'(result_valid), 1);
         chk("t3_hold_result", 32'(result), 6);
         chk("t3_hold_id", 32'(result_id), 1);
         chk("t3_hold_grant", 32'(grant), 32'h2);
      end
      @(negedge clock); result_ack = 1'b1; req = 4'b1000; #1;
      chk("t3_ack_rv", 32'(result_valid), 1);
      @(negedge clock); result_ack = 1'b0; #1;
      chk("t3_idle_grant", 32'(grant), 0);

      // 4: client 3 single sample 42 -> range 0
      one_sample(3, 16'd42, 1'b0, 4'b0001);

      // rf_error during a session flags the result
      rf_error = 1'b1;
      one_sample(0, 16'd5, 1'b1, 4'b0010);
      rf_error = 1'b0;

      // 5: TIMEOUT=8, client 1 sends 3 then stalls -> finish on 8th idle cycle
      @(negedge clock); drive(1, 1'b1, 1'b0, 16'd3); #1;
      chk("t5_grant", 32'(grant), 32'h2);
      chk("t5_go", 32'(rf_go), 1);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock); drive(0, 1'b0, 1'b0, '0); #1;
         chk("t5_idle_fin", 32'(rf_finish), 32'(i == 8));
         chk("t5_idle_data", 32'(rf_data_in), 3);
      end
      @(negedge clock); req = '0; #1;
      chk("t5_cap_busy", 32'(busy), 1);
      chk("t5_cap_fin", 32'(rf_finish), 0);
      @(negedge clock); #1;
      chk("t5_rv", 32'(result_valid), 1);
      chk("t5_err", 32'(result_err), 1);
      chk("t5_id", 32'(result_id), 1);
      chk("t5_result", 32'(result), 0);
      result_ack = 1'b1;
      @(negedge clock); result_ack = 1'b0; req = 4'b0100; #1;
      chk("t5_idle_busy", 32'(busy), 0);

      // 6: reset in STREAM clears everything; next session is clean
      @(negedge clock); drive(2, 1'b1, 1'b0, 16'd50); #1;
      chk("t6_go", 32'(rf_go), 1);
      @(negedge clock); drive(2, 1'b1, 1'b0, 16'd60); #1;
      chk("t6_stream_data", 32'(rf_data_in), 60);
      @(negedge clock); reset = 1'b1; #1;
      chk("t6_rst_grant", 32'(grant), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_ready", 32'(sample_ready), 0);
      chk("t6_rst_data", 32'(rf_data_in), 0);
      chk("t6_rst_fin", 32'(rf_finish), 0);
      chk("t6_rst_err", 32'(result_err), 0);
      @(negedge clock); reset = 1'b0; drive(0, 1'b0, 1'b0, '0); #1;
      one_sample(2, 16'd77, 1'b0, 4'b0000);

      $display("%0d/%0d checks passed", passes, passes + fails);
      $finish;
   end
endmodule
